core_modport: RTL and testbench

//  Memory-side port model for the 32-bit RISC-V core memory interfaces (instruction + data OBI-style req/gnt/rvalid).

---
 rtl/core_modport_pkg.sv | 23 ++
 rtl/core_modport_if.sv | 41 ++++
 rtl/core_modport_fifo.sv | 51 +++++
 rtl/core_modport.sv | 109 ++++++++++
 tb/tb_core_modport.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_modport_pkg.sv
// rtl/core_modport_pkg.sv - shared types and constants for the core memory-port model
package core_modport_pkg;

  localparam logic [31:0] FILL_INSTR_DEF = 32'h00000013;
  localparam int          STATS_W        = 32;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] mask_be(input logic [3:0] be, input logic [31:0] d);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/core_modport_if.sv
// rtl/core_modport_if.sv - driver, instruction, data and monitor signal bundle
interface core_modport_if #(parameter int W = 32);

  logic          drv_valid_i;
  logic [W-1:0]  drv_instr_i;
  logic          drv_ready_o;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [W-1:0]  instr_rdata_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          mon_valid_o;
  logic [31:0]   mon_addr_o;
  logic [3:0]    mon_be_o;
  logic [31:0]   mon_wdata_o;

  modport slave (
    input  drv_valid_i, drv_instr_i, instr_req_i, instr_addr_i,
           data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output drv_ready_o, instr_gnt_o, instr_rvalid_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_rdata_o,
           mon_valid_o, mon_addr_o, mon_be_o, mon_wdata_o
  );

  modport master (
    output drv_valid_i, drv_instr_i, instr_req_i, instr_addr_i,
           data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  drv_ready_o, instr_gnt_o, instr_rvalid_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_rdata_o,
           mon_valid_o, mon_addr_o, mon_be_o, mon_wdata_o
  );

endinterface

// File: rtl/core_modport_fifo.sv
// rtl/core_modport_fifo.sv - synchronous fetch-word FIFO, power-of-2 depth
module core_modport_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Refused operations are dropped here so callers never corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_modport.sv
// rtl/core_modport.sv - memory-side port model for core instr/data pins; PORT_STATS_EN adds fetch/store stats
module core_modport
  import core_modport_pkg::*;
#(
  parameter int                           INSTR_RDATA_WIDTH = 32,
  parameter int                           FIFO_DEPTH        = 4,
  parameter logic [INSTR_RDATA_WIDTH-1:0] FILL_INSTR        = FILL_INSTR_DEF,
  parameter logic [31:0]                  READ_DATA         = 32'h00000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  core_modport_if.slave       bus
`ifdef PORT_STATS_EN
  ,
  output logic [STATS_W-1:0]  fetch_cnt_o,
  output logic [STATS_W-1:0]  store_cnt_o,
  output logic [31:0]         last_fetch_addr_o
`endif
);

  localparam int W = INSTR_RDATA_WIDTH;

  logic                         fetch_go, data_go, store_go, q_push;
  logic                         q_full, q_empty;
  logic [W-1:0]                 q_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_q_count;
  mem_req_t                     req;

  logic          instr_rvalid_q, data_rvalid_q, mon_valid_q;
  logic [W-1:0]  instr_rdata_q;
  logic [31:0]   data_rdata_q, mon_addr_q, mon_wdata_q;
  logic [3:0]    mon_be_q;

  // Grants are zero-wait but must not leak out while reset is held.
  assign fetch_go = bus.instr_req_i & ~rst_i;
  assign data_go  = bus.data_req_i & ~rst_i;
  assign store_go = data_go & req.we;
  assign q_push   = bus.drv_valid_i & ~q_full;
  assign req      = '{we: bus.data_we_i, be: bus.data_be_i,
                      addr: bus.data_addr_i, wdata: bus.data_wdata_i};

  core_modport_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (q_push),
    .wdata (bus.drv_instr_i),
    .pop   (fetch_go),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (unused_q_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= '0;
      mon_valid_q    <= 1'b0;
      mon_addr_q     <= '0;
      mon_be_q       <= '0;
      mon_wdata_q    <= '0;
    end else begin
      instr_rvalid_q <= fetch_go;
      if (fetch_go) instr_rdata_q <= q_empty ? FILL_INSTR : q_head;
      data_rvalid_q  <= data_go;
      if (data_go) data_rdata_q <= req.we ? 32'h0 : READ_DATA;
      mon_valid_q    <= store_go;
      if (store_go) begin
        mon_addr_q  <= req.addr;
        mon_be_q    <= req.be;
        mon_wdata_q <= mask_be(req.be, req.wdata);
      end
    end
  end

  assign bus.drv_ready_o    = ~q_full;
  assign bus.instr_gnt_o    = fetch_go;
  assign bus.instr_rvalid_o = instr_rvalid_q;
  assign bus.instr_rdata_o  = instr_rdata_q;
  assign bus.data_gnt_o     = data_go;
  assign bus.data_rvalid_o  = data_rvalid_q;
  assign bus.data_rdata_o   = data_rdata_q;
  assign bus.mon_valid_o    = mon_valid_q;
  assign bus.mon_addr_o     = mon_addr_q;
  assign bus.mon_be_o       = mon_be_q;
  assign bus.mon_wdata_o    = mon_wdata_q;

`ifdef PORT_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o       <= '0;
      store_cnt_o       <= '0;
      last_fetch_addr_o <= '0;
    end else begin
      if (fetch_go) begin
        fetch_cnt_o       <= fetch_cnt_o + 1'b1;
        last_fetch_addr_o <= bus.instr_addr_i;
      end
      if (store_go) store_cnt_o <= store_cnt_o + 1'b1;
    end
  end
`else
  logic unused_instr_addr;
  assign unused_instr_addr = ^bus.instr_addr_i;
`endif

endmodule

// File: tb/tb_core_modport.sv
// tb/tb_core_modport.sv - table-driven bench for core_modport (default and PORT_STATS_EN builds)
module tb_core_modport;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  core_modport_if #(.W(32)) bus ();

`ifdef PORT_STATS_EN
  logic [31:0] fetch_cnt, store_cnt, last_fetch_addr;
`endif

  core_modport dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef PORT_STATS_EN
    ,
    .fetch_cnt_o       (fetch_cnt),
    .store_cnt_o       (store_cnt),
    .last_fetch_addr_o (last_fetch_addr)
`endif
  );

  typedef struct {
    logic        dv;
    logic [31:0] di;
    logic        ir;
    logic        dr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] da;
    logic [31:0] dw;
    logic        e_ready;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        e_mv;
    logic [31:0] e_ma;
    logic [3:0]  e_mb;
    logic [31:0] e_mw;
  } vec_t;

  vec_t vecs [14];
  logic [31:0] words [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.drv_valid_i  = 1'b0;
    bus.drv_instr_i  = 32'h0;
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[2]  = '{1'b1, 32'h002180B3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{1'b1, 32'h00000113, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'h002180B3, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'h00000113, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF,
                 1'b1, 1'b0, 32'h00000013, 1'b1, 32'h0, 1'b1, 32'h100, 4'h3, 32'h0000BEEF};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h100, 4'h3, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h55555555,
                 1'b1, 1'b0, 32'h00000013, 1'b1, 32'h0, 1'b0, 32'h100, 4'h3, 32'h0000BEEF};
    vecs[10] = '{1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 32'h100, 4'h3, 32'h0000BEEF};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 32'hAAAA0001, 1'b0, 32'h0, 1'b0, 32'h100, 4'h3, 32'h0000BEEF};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'hC, 32'h104, 32'h12345678,
                 1'b1, 1'b0, 32'hAAAA0001, 1'b1, 32'h0, 1'b1, 32'h104, 4'hC, 32'h12340000};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h9, 32'h108, 32'hA1B2C3D4,
                 1'b1, 1'b1, 32'h00000013, 1'b1, 32'h0, 1'b1, 32'h108, 4'h9, 32'hA10000D4};
    words[0] = 32'h00100093;
    words[1] = 32'h00200113;
    words[2] = 32'h00300193;
    words[3] = 32'h00400213;

    idle();
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    tick();
    tick();
    chk("rst_instr_gnt", 32'(bus.instr_gnt_o), 32'h0);
    chk("rst_data_gnt", 32'(bus.data_gnt_o), 32'h0);
    chk("rst_irvalid", 32'(bus.instr_rvalid_o), 32'h0);
    chk("rst_irdata", bus.instr_rdata_o, 32'h0);
    chk("rst_mon_valid", 32'(bus.mon_valid_o), 32'h0);
    chk("rst_ready", 32'(bus.drv_ready_o), 32'h1);
    idle();
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      bus.drv_valid_i  = vecs[i].dv;
      bus.drv_instr_i  = vecs[i].di;
      bus.instr_req_i  = vecs[i].ir;
      bus.instr_addr_i = 32'h1000 + 32'(i * 4);
      bus.data_req_i   = vecs[i].dr;
      bus.data_we_i    = vecs[i].dwe;
      bus.data_be_i    = vecs[i].dbe;
      bus.data_addr_i  = vecs[i].da;
      bus.data_wdata_i = vecs[i].dw;
      #1;
      chk($sformatf("v%0d_instr_gnt", i), 32'(bus.instr_gnt_o), 32'(vecs[i].ir));
      chk($sformatf("v%0d_data_gnt", i), 32'(bus.data_gnt_o), 32'(vecs[i].dr));
      tick();
      chk($sformatf("v%0d_ready", i), 32'(bus.drv_ready_o), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_irvalid", i), 32'(bus.instr_rvalid_o), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_irdata", i), bus.instr_rdata_o, vecs[i].e_ird);
      chk($sformatf("v%0d_drvalid", i), 32'(bus.data_rvalid_o), 32'(vecs[i].e_drv));
      chk($sformatf("v%0d_drdata", i), bus.data_rdata_o, vecs[i].e_drd);
      chk($sformatf("v%0d_mon_valid", i), 32'(bus.mon_valid_o), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d_mon_addr", i), bus.mon_addr_o, vecs[i].e_ma);
      chk($sformatf("v%0d_mon_be", i), 32'(bus.mon_be_o), 32'(vecs[i].e_mb));
      chk($sformatf("v%0d_mon_wdata", i), bus.mon_wdata_o, vecs[i].e_mw);
    end
    idle();
    tick();

    // Fill the queue, try a fifth push, then pop while full with the push still offered.
    for (int k = 0; k < 4; k++) begin
      bus.drv_valid_i = 1'b1;
      bus.drv_instr_i = words[k];
      tick();
    end
    chk("full_ready", 32'(bus.drv_ready_o), 32'h0);
    bus.drv_instr_i = 32'hBAD0BAD0;
    tick();
    chk("full_ready_hold", 32'(bus.drv_ready_o), 32'h0);
    bus.instr_req_i = 1'b1;
    tick();
    chk("full_pop_irdata", bus.instr_rdata_o, words[0]);
    chk("full_pop_ready", 32'(bus.drv_ready_o), 32'h1);
    bus.drv_valid_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d_irvalid", k), 32'(bus.instr_rvalid_o), 32'h1);
      chk($sformatf("drain%0d_irdata", k), bus.instr_rdata_o, words[k]);
    end
    tick();
    chk("drain_fill_irdata", bus.instr_rdata_o, 32'h00000013);
    idle();
    tick();

    // Reset lands after grants are seen but before the edge that would register them.
    bus.drv_valid_i = 1'b1;
    bus.drv_instr_i = 32'h11111111;
    tick();
    tick();
    idle();
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b1;
    bus.data_be_i   = 4'hF;
    bus.data_wdata_i = 32'hCAFEF00D;
    #1;
    chk("mid_instr_gnt", 32'(bus.instr_gnt_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_instr_gnt", 32'(bus.instr_gnt_o), 32'h0);
    chk("mid_rst_data_gnt", 32'(bus.data_gnt_o), 32'h0);
    tick();
    chk("mid_rst_irvalid", 32'(bus.instr_rvalid_o), 32'h0);
    chk("mid_rst_drvalid", 32'(bus.data_rvalid_o), 32'h0);
    chk("mid_rst_mon_valid", 32'(bus.mon_valid_o), 32'h0);
    chk("mid_rst_mon_wdata", bus.mon_wdata_o, 32'h0);
    idle();
    rst_i = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.drv_ready_o), 32'h1);
    chk("post_rst_irvalid", 32'(bus.instr_rvalid_o), 32'h0);
    bus.instr_req_i = 1'b1;
    tick();
    chk("post_rst_irvalid_fetch", 32'(bus.instr_rvalid_o), 32'h1);
    chk("post_rst_irdata_fill", bus.instr_rdata_o, 32'h00000013);
`ifdef PORT_STATS_EN
    chk("stats_fetch_cnt", fetch_cnt, 32'h1);
    chk("stats_store_cnt", store_cnt, 32'h0);
`endif
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
